// File: rtl/one_cycle_booth_multiplier.sv
// Signed radix-2 Booth multiplier: all partial products are summed in one cycle and the product is registered.
// Optional input capture stage under `BOOTH_INPUT_REG_EN (default build feeds the array straight from the ports).
module one_cycle_booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [2*WIDTH-1:0]   product
);

  logic signed [WIDTH-1:0]   x_arr;
  logic signed [WIDTH-1:0]   y_arr;
  logic signed [2*WIDTH-1:0] product_d;
  logic signed [2*WIDTH-1:0] product_q;

  // Booth digit for one recoded pair; x must already be sign-extended so -x of the minimum value fits.
  function automatic logic signed [2*WIDTH-1:0] booth_pp(
    input logic [1:0]                pair,
    input logic signed [2*WIDTH-1:0] xe
  );
    case (pair)
      2'b01:   booth_pp = xe;
      2'b10:   booth_pp = -xe;
      default: booth_pp = '0;
    endcase
  endfunction

`ifdef BOOTH_INPUT_REG_EN
  logic signed [WIDTH-1:0] x_d, x_q;
  logic signed [WIDTH-1:0] y_d, y_q;

  always_comb begin
    x_d = x;
    y_d = y;
  end

  // Input capture stage: isolates the array from port timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_arr = x_q;
  assign y_arr = y_q;
`else
  assign x_arr = x;
  assign y_arr = y;
`endif

  logic [WIDTH:0]            y_ext;
  logic signed [2*WIDTH-1:0] x_ext;
  logic signed [2*WIDTH-1:0] acc;

  always_comb begin
    y_ext = {y_arr, 1'b0};
    x_ext = {{WIDTH{x_arr[WIDTH-1]}}, x_arr};
    acc   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc = acc + (booth_pp({y_ext[i+1], y_ext[i]}, x_ext) <<< i);
    end
    product_d = acc;
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product_q <= '0;
    end else begin
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_one_cycle_booth_multiplier.sv
// Bench for one_cycle_booth_multiplier: directed corners, streaming random pairs and async reset,
// with expected products queued at drive time and popped when the pipeline delivers them.
module tb_one_cycle_booth_multiplier;

`ifdef BOOTH_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic [31:0] y;
  logic [63:0] product;

  typedef struct {
    logic signed [63:0] v;
    string              tag;
  } exp_t;

  exp_t sb[$];
  exp_t item;
  int   tests;
  int   fails;

  one_cycle_booth_multiplier #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .y       (y),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_now(input logic signed [63:0] e, input string tag);
    tests++;
    assert (product === e) else begin
      fails++;
      $error("FAIL %s: product=%0d expected=%0d", tag, $signed(product), e);
    end
  endtask

  // Drive one operand pair for one cycle; compare whatever the pipeline delivers after the edge.
  task automatic step(input logic [31:0] xi, input logic [31:0] yi,
                      input logic signed [63:0] e, input string tag);
    @(negedge clk);
    x = xi;
    y = yi;
    sb.push_back('{e, tag});
    @(posedge clk);
    #1;
    if (sb.size() == LAT) begin
      item = sb.pop_front();
      check_now(item.v, item.tag);
    end
  endtask

  // Hold a pair for three cycles so each directed case is seen once it has settled.
  task automatic hold(input logic [31:0] xi, input logic [31:0] yi,
                      input logic signed [63:0] e, input string tag);
    for (int k = 0; k < 3; k++) step(xi, yi, e, tag);
  endtask

  initial begin
    logic signed [31:0] xs;
    logic signed [31:0] ys;
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    x     = '0;
    y     = '0;
    #3;
    check_now(64'sd0, "reset_zero");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    hold(32'd2,          -32'sd5,       -64'sd10,  "mix_2x-5");
    hold(-32'sd3,        32'd21,        -64'sd63,  "mix_-3x21");
    hold(32'd12,         32'd5,         64'sd60,   "pos_12x5");
    hold(-32'sd20,       -32'sd11,      64'sd220,  "neg_-20x-11");
    hold(32'd65535,      32'd1,         64'sd65535, "ident");
    hold(32'd100,        32'd0,         64'sd0,    "y_zero");
    hold(32'd0,          32'h8000_0000, 64'sd0,    "x_zero");
    hold(-32'sd4,        32'h8000_0000, 64'sd8589934592, "ymin");
    hold(32'h8000_0000,  32'd3,         -64'sd6442450944, "xmin");
    hold(32'h7FFF_FFFF,  32'h8000_0000, -64'sd4611686016279904256, "max_x_min");
    hold(32'h8000_0000,  32'h8000_0000, 64'sh4000_0000_0000_0000, "min_x_min");

    // Streaming: new pair every cycle, product must follow with the pipeline latency.
    for (int n = 0; n < 24; n++) begin
      xs = $urandom;
      ys = (n % 5 == 0) ? 32'sh8000_0000 : $urandom;
      if (n % 7 == 3) xs = 32'sh8000_0000;
      step(xs, ys, 64'(xs) * 64'(ys), "stream");
    end

    // Async reset between edges must clear the output without a clock edge.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_now(64'sd0, "async_reset");
    sb.delete();
    @(negedge clk);
    check_now(64'sd0, "reset_held");
    rst = 1'b1;
    hold(-32'sd7,        32'd9,         -64'sd63,  "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
